awgn_channel_adder: RTL and testbench
=====================================

// Module: awgn_channel_adder
// PURPOSE
//   Downstream stage of the AWGN IP core.
//   - Accepts one Gaussian noise pair (x0, x1) per cycle from the core.
//   - Buffers the pairs in a FIFO and serialises them as x0 first, then x1.
//   - Scales each noise sample, adds it to an incoming signal stream and
//     emits the noisy sample on a valid/ready output.
//   - Forms the channel-model output of the noise generator.
// PARAMETERS
//   DATA_W  16  width of signal, noise and output samples (two's complement)
//   DEPTH   8   noise FIFO depth in pairs; must be a power of 2 and >= 2
//   SCALE_W 4   width of the noise attenuation (shift) control
// PORTS
//   clk        in   1               rising-edge clock
//   reset      in   1               asynchronous reset, active-low (0 = reset)
//   nz_valid   in   1               x0/x1 pair is valid this cycle
//   x0         in   DATA_W          noise sample 0 (signed)
//   x1         in   DATA_W          noise sample 1 (signed)
//   nz_ready   out  1               FIFO not full (level < DEPTH)
//   sig_valid  in   1               signal sample valid
//   sig_data   in   DATA_W          signal sample (signed)
//   sig_ready  out  1               signal sample is consumed this cycle
//   scale      in   SCALE_W         arithmetic right shift applied to noise
//   out_valid  out  1               out_data holds a valid sample
//   out_data   out  DATA_W          sig_data + (noise >>> scale)
//   out_ready  in   1               downstream accepts out_data
//   fifo_level out  $clog2(DEPTH)+1 pairs currently stored
//   overflow   out  1               sticky: a pair was dropped because the FIFO was full
// BEHAVIOUR
//   - Reset (reset=0, async):
//     - FIFO empty; read/write pointers = 0; phase = 0.
//     - out_valid = 0, out_data = 0, fifo_level = 0, overflow = 0.
//     - nz_ready = 1 once reset is released.
//     - Asserting reset mid-stream discards all buffered data and output immediately.
//   - Push: when nz_valid && nz_ready, {x1,x0} is written at wptr; wptr increments mod DEPTH.
//   - Full:
//     - nz_valid while level == DEPTH drops the pair and sets overflow = 1 until reset.
//     - This holds even if a pop happens in the same cycle.
//     - nz_ready is derived from the registered level only.
//   - Read phase bit:
//     - phase = 0 selects x0 of the head pair; phase = 1 selects x1.
//     - Consuming at phase 0 sets phase = 1.
//     - Consuming at phase 1 pops the pair (rptr+1) and clears phase.
//   - Consume condition:
//     - sig_ready = sig_valid && level != 0 && (!out_valid || out_ready); combinational.
//     - Empty FIFO means sig_ready = 0, and the signal stream stalls.
//   - Arithmetic:
//     - noise_s = head_sample >>> scale (sign-preserving).
//     - sum = sig_data + noise_s, computed in DATA_W+1 bits, then reduced to DATA_W
//       according to CONFIGURATION.
//   - Output:
//     - Registered; latency is 1 cycle from sig_ready to out_valid.
//     - Under out_ready = 0, out_valid and out_data hold stable.
//     - When out_ready && !consume, out_valid clears.
//   - Simultaneous push and pop: level unchanged; both pointers advance.
//   - Pointer wrap: natural modulo DEPTH; level counts 0..DEPTH inclusive.
// CONFIGURATION
//   - AWGN_SAT_ADD_EN defined:
//     - The DATA_W+1 sum saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//     - For DATA_W = 16 that is 0x8000..0x7FFF.
//   - AWGN_SAT_ADD_EN undefined: the sum wraps; out_data = sum[DATA_W-1:0].
// TESTING
//   1. Reset:
//      - reset=0 for 3 cycles with random inputs.
//      - Expect out_valid=0, out_data=0, fifo_level=0, overflow=0.
//      - Expect nz_ready=1 after release.
//   2. Serialisation:
//      - Push x0=0x0100, x1=0xFF00; set scale=0; send two sig_data=0x0010 with out_ready=1.
//      - Expect out_data 0x0110 then 0xFF10, and fifo_level 1 -> 0.
//   3. Scaling:
//      - scale=4, x0=0x0100, sig_data=0x1000.
//      - Expect out_data=0x1010.
//      - Also scale=4, x0=0xFF00: expect noise 0xFFF0.
//   4. Saturation:
//      - sig_data=0x7FF0, x0=0x0100.
//      - Expect 0x7FFF with AWGN_SAT_ADD_EN, and 0x80F0 without it.
//   5. Overflow:
//      - Push 9 pairs with sig_valid=0.
//      - Expect fifo_level=8, nz_ready=0 after the 8th, the 9th pair dropped, overflow=1 (sticky).
//   6. Backpressure and reset:
//      - Hold out_ready=0 for 5 cycles: out_data stable, sig_ready=0.
//      - Then assert reset mid-stream: everything clears within the same cycle.

Source files
------------

// File: rtl/awgn_channel_adder.sv
// awgn_channel_adder: buffers Gaussian noise pairs, serialises them x0 then x1, scales each
// sample and adds it to a signal stream. Define AWGN_SAT_ADD_EN for a saturating add (default wraps).
module awgn_channel_adder #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8,
    parameter int SCALE_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   nz_valid,
    input  logic [DATA_W-1:0]      x0,
    input  logic [DATA_W-1:0]      x1,
    output logic                   nz_ready,
    input  logic                   sig_valid,
    input  logic [DATA_W-1:0]      sig_data,
    output logic                   sig_ready,
    input  logic [SCALE_W-1:0]     scale,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [2*DATA_W-1:0]      mem [DEPTH];
    logic [AW-1:0]            wptr;
    logic [AW-1:0]            rptr;
    logic [LW-1:0]            level;
    logic                     phase;
    logic                     ovf;
    logic                     push;
    logic                     pop;
    logic                     consume;
    logic [2*DATA_W-1:0]      head;
    logic signed [DATA_W-1:0] sample_s;
    logic signed [DATA_W-1:0] noise_s;
    logic signed [DATA_W-1:0] sig_s;
    logic signed [DATA_W:0]   sum_p0;
    logic                     vld_p1;
    logic [DATA_W-1:0]        data_p1;

    function automatic logic [DATA_W-1:0] reduce_sum(input logic signed [DATA_W:0] s);
`ifdef AWGN_SAT_ADD_EN
        if (s[DATA_W] != s[DATA_W-1])
            reduce_sum = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            reduce_sum = s[DATA_W-1:0];
`else
        reduce_sum = s[DATA_W-1:0];
`endif
    endfunction

    // Flow control looks only at the registered level, so a pop cannot free a slot in the same cycle.
    assign nz_ready = (level != FULL_LVL);
    assign push     = nz_valid && nz_ready;
    assign consume  = sig_valid && (level != '0) && (!vld_p1 || out_ready);
    assign pop      = consume && phase;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {x1, x0};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            phase <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (consume)
                phase <= ~phase;
            if (nz_valid && !nz_ready)
                ovf <= 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Stage p0: select head sample, scale, widen and add
    always_comb begin
        head     = mem[rptr];
        sample_s = phase ? head[2*DATA_W-1:DATA_W] : head[DATA_W-1:0];
        noise_s  = sample_s >>> scale;
        sig_s    = sig_data;
        sum_p0   = {sig_s[DATA_W-1], sig_s} + {noise_s[DATA_W-1], noise_s};
    end

    // Stage p1: registered output, held while downstream stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (consume) begin
            vld_p1  <= 1'b1;
            data_p1 <= reduce_sum(sum_p0);
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid  = vld_p1;
    assign out_data   = data_p1;
    assign sig_ready  = consume;
    assign fifo_level = level;
    assign overflow   = ovf;

endmodule

// File: tb/tb_awgn_channel_adder.sv
// Scoreboard bench for awgn_channel_adder: a flat sample-queue reference model predicts every
// handshake and output value; a negedge monitor compares the DUT against it.
module tb_awgn_channel_adder;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 8;
    localparam int SCALE_W = 4;

`ifdef AWGN_SAT_ADD_EN
    localparam logic [15:0] EXP_POS = 16'h7FFF;
    localparam logic [15:0] EXP_NEG = 16'h8000;
`else
    localparam logic [15:0] EXP_POS = 16'h80F0;
    localparam logic [15:0] EXP_NEG = 16'h7F00;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                nz_valid;
    logic [DATA_W-1:0]   x0;
    logic [DATA_W-1:0]   x1;
    logic                nz_ready;
    logic                sig_valid;
    logic [DATA_W-1:0]   sig_data;
    logic                sig_ready;
    logic [SCALE_W-1:0]  scale;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_ready;
    logic [3:0]          fifo_level;
    logic                overflow;

    awgn_channel_adder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SCALE_W(SCALE_W)) dut (
        .clk(clk), .reset(reset),
        .nz_valid(nz_valid), .x0(x0), .x1(x1), .nz_ready(nz_ready),
        .sig_valid(sig_valid), .sig_data(sig_data), .sig_ready(sig_ready),
        .scale(scale),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: noise is a flat queue of samples in consumption order.
    int          samples[$];
    logic [15:0] sb[$];
    bit          m_ov;
    bit          m_ovf;
    bit          p_consume;
    bit          p_nz_ready;
    int          p_level;
    bit          chk_en;
    int          n_cmp;
    int          n_bad;
    logic [15:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_out(input logic [15:0] s, input int n, input logic [3:0] sh);
        int r;
        r = int'($signed(s)) + (n >>> sh);
`ifdef AWGN_SAT_ADD_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic model_reset();
        samples.delete();
        sb.delete();
        m_ov  = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Inputs must already be set; predicts this cycle, then applies the clock edge to the model.
    task automatic step();
        int lvl;
        lvl        = (samples.size() + 1) / 2;
        p_level    = lvl;
        p_nz_ready = (lvl < DEPTH);
        p_consume  = sig_valid && (lvl != 0) && (!m_ov || out_ready);
        @(posedge clk);
        if (nz_valid && !p_nz_ready)
            m_ovf = 1'b1;
        if (p_consume) begin
            sb.push_back(ref_out(sig_data, samples.pop_front(), scale));
            m_ov = 1'b1;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (nz_valid && p_nz_ready) begin
            samples.push_back(int'($signed(x0)));
            samples.push_back(int'($signed(x1)));
        end
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset && chk_en) begin
            check("sig_ready",  32'(sig_ready),  32'(p_consume));
            check("nz_ready",   32'(nz_ready),   32'(p_nz_ready));
            check("fifo_level", 32'(fifo_level), 32'(p_level));
            check("overflow",   32'(overflow),   32'(m_ovf));
            check("out_valid",  32'(out_valid),  32'(m_ov));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_data at %0t: got 0x%0h with no expected sample queued", $time, out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(sb[0]));
                    if (out_ready)
                        void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        reset = 1'b0;
        model_reset();

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            nz_valid  = 1'($urandom);
            x0        = 16'($urandom);
            x1        = 16'($urandom);
            sig_valid = 1'($urandom);
            sig_data  = 16'($urandom);
            scale     = 4'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid),  32'd0);
            check("rst_out_data",  32'(out_data),   32'd0);
            check("rst_level",     32'(fifo_level), 32'd0);
            check("rst_overflow",  32'(overflow),   32'd0);
        end
        @(posedge clk);
        #1;
        nz_valid = 1'b0; sig_valid = 1'b0; out_ready = 1'b1; scale = '0;
        reset = 1'b1;
        #1;
        check("nz_ready_after_reset", 32'(nz_ready), 32'd1);
        chk_en = 1'b1;

        // Serialisation
        nz_valid = 1'b1; x0 = 16'h0100; x1 = 16'hFF00; step();
        nz_valid = 1'b0; sig_valid = 1'b1; sig_data = 16'h0010; step();
        check("ser_x0",   32'(out_data),   32'h0110);
        check("ser_lvl1", 32'(fifo_level), 32'd1);
        step();
        check("ser_x1",   32'(out_data),   32'hFF10);
        check("ser_lvl0", 32'(fifo_level), 32'd0);
        sig_valid = 1'b0; step();

        // Scaling
        scale = 4'd4;
        nz_valid = 1'b1; x0 = 16'h0100; x1 = 16'hFF00; step();
        nz_valid = 1'b0; sig_valid = 1'b1; sig_data = 16'h1000; step();
        check("scale_pos", 32'(out_data), 32'h1010);
        step();
        check("scale_neg", 32'(out_data), 32'h0FF0);
        sig_valid = 1'b0; step();

        // Add limits
        scale = 4'd0;
        nz_valid = 1'b1; x0 = 16'h0100; x1 = 16'hFF00; step();
        nz_valid = 1'b0; sig_valid = 1'b1; sig_data = 16'h7FF0; step();
        check("sat_pos", 32'(out_data), 32'(EXP_POS));
        sig_data = 16'h8000; step();
        check("sat_neg", 32'(out_data), 32'(EXP_NEG));
        sig_valid = 1'b0; step();

        // Overflow
        for (int i = 1; i <= 9; i++) begin
            nz_valid = 1'b1; x0 = pick(); x1 = pick(); step();
            if (i == 8) begin
                check("full_level",    32'(fifo_level), 32'd8);
                check("full_nz_ready", 32'(nz_ready),   32'd0);
                check("full_no_ovf",   32'(overflow),   32'd0);
            end
        end
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_set",   32'(overflow),   32'd1);
        nz_valid = 1'b0;
        repeat (3) step();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Backpressure then asynchronous reset mid-stream
        scale = 4'($urandom_range(0, 15));
        sig_valid = 1'b1; sig_data = pick(); out_ready = 1'b1; step();
        out_ready = 1'b0;
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            sig_data = pick(); step();
            check("bp_valid",     32'(out_valid), 32'd1);
            check("bp_stable",    32'(out_data),  32'(held));
            check("bp_sig_ready", 32'(sig_ready), 32'd0);
        end
        #2;
        reset = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid),  32'd0);
        check("mrst_out_data",  32'(out_data),   32'd0);
        check("mrst_level",     32'(fifo_level), 32'd0);
        check("mrst_overflow",  32'(overflow),   32'd0);
        check("mrst_sig_ready", 32'(sig_ready),  32'd0);
        chk_en = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1; sig_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("mrst_nz_ready", 32'(nz_ready), 32'd1);
        chk_en = 1'b1;

        // Randomized traffic with varying producer/consumer pressure
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 400; i++) begin
                nz_valid  = ($urandom_range(0, 5) < seg);
                x0        = pick();
                x1        = pick();
                sig_valid = ($urandom_range(0, 5) >= seg / 2);
                sig_data  = pick();
                out_ready = ($urandom_range(0, 3) != 0) || (seg == 5);
                scale     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
                step();
            end
        end

        // Drain
        nz_valid = 1'b0; sig_valid = 1'b1; out_ready = 1'b1;
        repeat (2 * DEPTH + 4) step();
        sig_valid = 1'b0;
        repeat (3) step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
